simon_sequencer: RTL

Parametrised Simon game engine that replaces the hard-wired four-button game controller with a reusable core. It generates a pseudo-random colour sequence, plays it back on an LED colour bus, checks the player's debounced button presses against it, and keeps the score. It sits between the per-button debouncers and the LED/LCD drivers; the top level only maps its outputs to display text and LED pins.

---
 rtl/simon_sequencer_if.sv | 23 ++
 rtl/simon_sequencer.sv | 113 +++++++++++
 2 files changed

// File: rtl/simon_sequencer_if.sv
// simon_sequencer_if: game-control and LED/score bus between the Simon engine and its surroundings
interface simon_sequencer_if #(
  parameter int NUM_BTNS = 4,
  parameter int CW = $clog2(NUM_BTNS)
);
  logic start;
  logic [15:0] seed;
  logic [NUM_BTNS-1:0] btn_pressed;
  logic led_on;
  logic [CW-1:0] led_color;
  logic [7:0] score;
  logic [1:0] phase;
  logic game_over;
  logic won;
  modport master (
    output start, seed, btn_pressed,
    input led_on, led_color, score, phase, game_over, won
  );
  modport slave (
    input start, seed, btn_pressed,
    output led_on, led_color, score, phase, game_over, won
  );
endinterface

// File: rtl/simon_sequencer.sv
// simon_sequencer: Simon game engine -- LFSR sequence generation, LED playback, press checking and scoring
module simon_sequencer #(
  parameter int NUM_BTNS = 4,
  parameter int MAX_LEN = 32,
  parameter int ON_CYCLES = 12_000_000,
  parameter int OFF_CYCLES = 6_000_000,
  parameter int TIMEOUT_CYCLES = 150_000_000
) (
  input logic clk,
  input logic reset,
  simon_sequencer_if.slave io
);
  localparam int CW = $clog2(NUM_BTNS);
  localparam int AW = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;
  localparam logic [15:0] SEED_DEF = 16'hACE1;
  localparam logic [7:0] NB8 = 8'(NUM_BTNS);
  localparam logic [7:0] LEN_MAX = 8'(MAX_LEN);
  localparam logic [31:0] ON_END = 32'(ON_CYCLES - 1);
  localparam logic [31:0] OFF_END = 32'(OFF_CYCLES - 1);
  localparam logic [31:0] TO_END = 32'(TIMEOUT_CYCLES - 1);
  typedef enum logic [3:0] {
    IDLE, ADD, SHOW_ON, SHOW_OFF, WAIT, ECHO, ROUND_DONE, LOSE, WIN
  } state_t;
  state_t state, state_n;
  logic [15:0] lfsr, lfsr_step;
  logic [7:0] len, idx, score;
  logic [31:0] tmr;
  logic [CW-1:0] seq [2**AW];
  logic [CW-1:0] cur, new_col;
  logic [NUM_BTNS-1:0] want;
  logic restart, last;
  logic led_on_d, game_over_d, won_d;
  logic [CW-1:0] led_color_d;
  logic [1:0] phase_d;
  logic led_on_q, game_over_q, won_q;
  logic [CW-1:0] led_color_q;
  logic [1:0] phase_q;
  assign lfsr_step = {1'b0, lfsr[15:1]} ^ (lfsr[0] ? 16'hB400 : 16'h0000);
  assign new_col = CW'(lfsr[7:0] % NB8);
  assign cur = seq[idx[AW-1:0]];
  assign want = NUM_BTNS'(1) << cur;
  assign last = (idx + 8'd1) == len;
  assign restart = io.start && (state == IDLE || state == LOSE || state == WIN);
  // Every state change restarts the cycle timer, so each dwell counts from 0.
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      lfsr <= SEED_DEF;
      len <= '0;
      idx <= '0;
      score <= '0;
      tmr <= '0;
      led_on_q <= 1'b0;
      led_color_q <= '0;
      phase_q <= '0;
      game_over_q <= 1'b0;
      won_q <= 1'b0;
    end else begin
      state <= state_n;
      tmr <= (state_n != state) ? '0 : tmr + 32'd1;
      lfsr <= restart ? ((io.seed == '0) ? SEED_DEF : io.seed) : (state != IDLE) ? lfsr_step : lfsr;
      if (restart) begin
        len <= '0;
        idx <= '0;
        score <= '0;
      end else if (state == ADD) begin
        len <= len + 8'd1;
        idx <= '0;
      end else if ((state == SHOW_OFF || state == ECHO) && state_n != state) begin
        idx <= last ? '0 : idx + 8'd1;
      end
      if (state == ROUND_DONE && tmr == '0) score <= score + 8'd1;
      led_on_q <= led_on_d;
      led_color_q <= led_color_d;
      phase_q <= phase_d;
      game_over_q <= game_over_d;
      won_q <= won_d;
    end
  end
  always_ff @(posedge clk) begin
    if (state == ADD) seq[len[AW-1:0]] <= new_col;
  end
  always_comb begin
    state_n = state;
    case (state)
      IDLE, LOSE, WIN: state_n = restart ? ADD : state;
      ADD: state_n = SHOW_ON;
      SHOW_ON: state_n = (tmr == ON_END) ? SHOW_OFF : SHOW_ON;
      SHOW_OFF: state_n = (tmr != OFF_END) ? SHOW_OFF : last ? WAIT : SHOW_ON;
      WAIT: state_n = (io.btn_pressed == want) ? ECHO :
                      (|io.btn_pressed || tmr == TO_END) ? LOSE : WAIT;
      ECHO: state_n = (tmr != ON_END) ? ECHO : last ? ROUND_DONE : WAIT;
      ROUND_DONE: state_n = (len == LEN_MAX) ? WIN : (tmr == OFF_END) ? ADD : ROUND_DONE;
      default: state_n = IDLE;
    endcase
  end
  // Echo and lose both light the entry at idx: the pressed colour equals it, or it is the one missed.
  always_comb begin
    led_on_d = state inside {SHOW_ON, ECHO, LOSE};
    led_color_d = led_on_d ? cur : '0;
    phase_d = (state == IDLE) ? 2'd0 :
              (state inside {ADD, SHOW_ON, SHOW_OFF}) ? 2'd1 :
              (state inside {WAIT, ECHO, ROUND_DONE}) ? 2'd2 : 2'd3;
    game_over_d = state inside {LOSE, WIN};
    won_d = state == WIN;
  end
  assign io.led_on = led_on_q;
  assign io.led_color = led_color_q;
  assign io.score = score;
  assign io.phase = phase_q;
  assign io.game_over = game_over_q;
  assign io.won = won_q;
endmodule
